// File: rtl/mmio_bus_master.sv
// mmio_bus_master: FIFO-buffered initiator for the single-cycle MMIO bus, one access at a time.
// Read-modify-write support is compiled in when MMIO_RMW_EN is defined.
module mmio_bus_master #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic              i_cmd_rmw,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   input  logic [DATA_W-1:0] i_cmd_mask,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_write,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   output logic              o_mem_re,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

`ifdef MMIO_RMW_EN
   typedef enum logic [1:0] {StIdle, StAccess, StRmwWr, StResp} state_t;
`else
   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;
`endif

   state_t r_state, w_state_d;

   logic              r_fifo_write [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_wdata [FIFO_DEPTH];
`ifdef MMIO_RMW_EN
   logic              r_fifo_rmw   [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_mask  [FIFO_DEPTH];
   logic              r_cur_rmw;
   logic [DATA_W-1:0] r_cur_mask;
`endif
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_cur_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic w_full, w_empty, w_push, w_pop, w_access_read;
   logic w_mem_we, w_mem_re, w_rsp_valid;

   assign w_full  = (r_count == DEPTH_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = i_cmd_valid && !w_full;
   assign w_pop   = (r_state == StIdle) && !w_empty;

`ifdef MMIO_RMW_EN
   assign w_access_read = !r_cur_write || r_cur_rmw;
`else
   assign w_access_read = !r_cur_write;
   logic w_unused;
   assign w_unused = ^{i_cmd_rmw, i_cmd_mask};
`endif

   // Payload storage needs no reset; only pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_write[r_wr_ptr] <= i_cmd_write;
         r_fifo_addr[r_wr_ptr]  <= i_cmd_addr;
         r_fifo_wdata[r_wr_ptr] <= i_cmd_wdata;
`ifdef MMIO_RMW_EN
         r_fifo_rmw[r_wr_ptr]   <= i_cmd_rmw;
         r_fifo_mask[r_wr_ptr]  <= i_cmd_mask;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsp_rdata <= '0;
`ifdef MMIO_RMW_EN
         r_cur_rmw   <= 1'b0;
         r_cur_mask  <= '0;
`endif
      end else begin
         if (w_pop) begin
            r_cur_write <= r_fifo_write[r_rd_ptr];
            r_mem_addr  <= r_fifo_addr[r_rd_ptr];
            r_mem_wdata <= r_fifo_wdata[r_rd_ptr];
`ifdef MMIO_RMW_EN
            r_cur_rmw   <= r_fifo_rmw[r_rd_ptr] && r_fifo_write[r_rd_ptr];
            r_cur_mask  <= r_fifo_mask[r_rd_ptr];
`endif
         end
         if (r_state == StAccess) begin
            r_rsp_rdata <= w_access_read ? i_mem_rdata : '0;
`ifdef MMIO_RMW_EN
            // r_mem_wdata still holds the command data here; merge it into the read value.
            if (r_cur_rmw) r_mem_wdata <= (i_mem_rdata & ~r_cur_mask) | (r_mem_wdata & r_cur_mask);
`endif
         end
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_rsp_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!w_empty) w_state_d = StAccess;
         end
         StAccess: begin
            w_mem_re  = w_access_read;
            w_mem_we  = !w_access_read;
`ifdef MMIO_RMW_EN
            w_state_d = r_cur_rmw ? StRmwWr : StResp;
`else
            w_state_d = StResp;
`endif
         end
`ifdef MMIO_RMW_EN
         StRmwWr: begin
            w_mem_we  = 1'b1;
            w_state_d = StResp;
         end
`endif
         StResp: begin
            w_rsp_valid = 1'b1;
            if (i_rsp_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_cmd_ready = !w_full;
   assign o_rsp_valid = w_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_write = r_cur_write;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = w_mem_we;
   assign o_mem_re    = w_mem_re;
   assign o_busy      = (r_state != StIdle) || !w_empty;
endmodule
